// File: rtl/operand_fetch.sv
// Issue stage ahead of the integer ALU: decodes RV32I ALU-class instructions, reads the
// register file with write-back bypass and ALU-result forwarding, and stalls on pending registers.
module operand_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_ir,
   input  logic [31:0] in_pc,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        lock_en,
   input  logic [4:0]  lock_rd,
   input  logic [31:0] alu_rslt,
   output logic        out_valid,
   output logic [4:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] opd1,
   output logic [31:0] opd2,
   output logic [4:0]  out_rd
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned RW   = 5;

   localparam logic [4:0] OPC_OP    = 5'b01100;
   localparam logic [4:0] OPC_OPIMM = 5'b00100;
   localparam logic [4:0] OPC_LUI   = 5'b01101;
   localparam logic [4:0] OPC_AUIPC = 5'b00101;

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] pend, pend_n;
   logic [XLEN-1:0] opd1_q, opd2_q;
   logic            fwd1_q, fwd2_q;

   logic [RW-1:0]   dec_opc, rs1, rs2, rd;
   logic            is_op, is_opimm, is_lui, is_auipc, is_alu;
   logic            uses_rs1, uses_rs2, accept, fwd1_d, fwd2_d;
   logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, opd1_d, opd2_d;
   logic [2:0]      f3_d;
   logic [6:0]      f7_d;
   logic            unused_ir;

   assign unused_ir = ^in_ir[1:0];

   // Decode, register read with write-first bypass, and operand selection
   always_comb begin
      dec_opc  = in_ir[6:2];
      rs1      = in_ir[19:15];
      rs2      = in_ir[24:20];
      rd       = in_ir[11:7];
      is_op    = (dec_opc == OPC_OP);
      is_opimm = (dec_opc == OPC_OPIMM);
      is_lui   = (dec_opc == OPC_LUI);
      is_auipc = (dec_opc == OPC_AUIPC);
      is_alu   = is_op | is_opimm | is_lui | is_auipc;
      uses_rs1 = is_op | is_opimm;
      uses_rs2 = is_op;

      imm_i = {{20{in_ir[31]}}, in_ir[31:20]};
      imm_u = {in_ir[31:12], 12'b0};

      rs1_val = '0;
      if (rs1 != '0)
         rs1_val = (wb_en && (wb_rd == rs1)) ? wb_data : rf[rs1];
      rs2_val = '0;
      if (rs2 != '0)
         rs2_val = (wb_en && (wb_rd == rs2)) ? wb_data : rf[rs2];

      opd1_d = rs1_val;
      if (is_lui)
         opd1_d = '0;
      else if (is_auipc)
         opd1_d = in_pc;

      opd2_d = imm_u;
      if (is_op)
         opd2_d = rs2_val;
      else if (is_opimm)
         opd2_d = imm_i;

      f3_d = in_ir[14:12];
      f7_d = in_ir[31:25];
      if (is_lui || is_auipc) begin
         f3_d = 3'b000;
         f7_d = 7'b0000000;
      end

      // The instruction issuing now delivers its result on alu_rslt next cycle
      fwd1_d = uses_rs1 && out_valid && (out_rd != '0) && (out_rd == rs1);
      fwd2_d = uses_rs2 && out_valid && (out_rd != '0) && (out_rd == rs2);

      in_ready = !(uses_rs1 && pend[rs1]) && !(uses_rs2 && pend[rs2]) &&
                 !((rd != '0) && pend[rd]);
      accept   = in_valid && in_ready;
   end

   // Scoreboard: a lock in the same cycle as a write-back to that register wins
   always_comb begin
      pend_n = pend;
      if (wb_en && (wb_rd != '0))
         pend_n[wb_rd] = 1'b0;
      if (lock_en && (lock_rd != '0))
         pend_n[lock_rd] = 1'b1;
      pend_n[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         out_valid <= 1'b0;
         opcode    <= '0;
         funct3    <= '0;
         funct7    <= '0;
         opd1_q    <= '0;
         opd2_q    <= '0;
         out_rd    <= '0;
         fwd1_q    <= 1'b0;
         fwd2_q    <= 1'b0;
      end else begin
         pend      <= pend_n;
         out_valid <= accept && is_alu;
         fwd1_q    <= accept && fwd1_d;
         fwd2_q    <= accept && fwd2_d;
         if (accept) begin
            opcode <= dec_opc;
            funct3 <= f3_d;
            funct7 <= f7_d;
            opd1_q <= opd1_d;
            opd2_q <= opd2_d;
            out_rd <= rd;
         end
      end
   end

   // Register file storage; x0 is never written
   always_ff @(posedge clk) begin
      if (wb_en && (wb_rd != '0))
         rf[wb_rd] <= wb_data;
   end

   assign opd1 = fwd1_q ? alu_rslt : opd1_q;
   assign opd2 = fwd2_q ? alu_rslt : opd2_q;

endmodule
